blob_tracker: RTL and testbench

//  Consumes the RGB565 camera pixel stream, classifies each pixel against the magenta colour window and

---
 rtl/blob_tracker_pkg.sv | 26 ++
 rtl/colour_window_match.sv | 23 ++
 rtl/blob_tracker.sv | 168 ++++++++++++++++
 tb/tb_blob_tracker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_tracker_pkg.sv
// Shared camera definitions: default colour window, RGB565 field positions, default frame size
// and the blob tracker FSM state type.
package blob_tracker_pkg;

  localparam int unsigned WIDTH_DEF  = 640;
  localparam int unsigned HEIGHT_DEF = 480;

  localparam int unsigned R_MIN_DEF = 24;
  localparam int unsigned G_MAX_DEF = 15;
  localparam int unsigned B_MIN_DEF = 24;

  localparam int unsigned R_LSB  = 11;
  localparam int unsigned R_BITS = 5;
  localparam int unsigned G_LSB  = 5;
  localparam int unsigned G_BITS = 6;
  localparam int unsigned B_LSB  = 0;
  localparam int unsigned B_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH,
    ST_PUBLISH
  } state_t;

endpackage

// File: rtl/colour_window_match.sv
// Combinational RGB565 colour-window classifier; also used by the display overlay path.
module colour_window_match
  import blob_tracker_pkg::*;
#(
  parameter int unsigned R_MIN = R_MIN_DEF,
  parameter int unsigned G_MAX = G_MAX_DEF,
  parameter int unsigned B_MIN = B_MIN_DEF
) (
  input  logic [15:0] pixel,
  output logic        match_c
);

  logic [R_BITS-1:0] r;
  logic [G_BITS-1:0] g;
  logic [B_BITS-1:0] b;

  assign r = pixel[R_LSB +: R_BITS];
  assign g = pixel[G_LSB +: G_BITS];
  assign b = pixel[B_LSB +: B_BITS];

  assign match_c = (r >= R_BITS'(R_MIN)) && (g <= G_BITS'(G_MAX)) && (b >= B_BITS'(B_MIN));

endmodule

// File: rtl/blob_tracker.sv
// Per-frame statistics of colour-window matching pixels (count, coordinate sums, bounding box),
// published to the CPU through a valid/ack result register bank.
module blob_tracker
  import blob_tracker_pkg::*;
#(
  parameter  int unsigned WIDTH  = WIDTH_DEF,
  parameter  int unsigned HEIGHT = HEIGHT_DEF,
  parameter  int unsigned R_MIN  = R_MIN_DEF,
  parameter  int unsigned G_MAX  = G_MAX_DEF,
  parameter  int unsigned B_MIN  = B_MIN_DEF,
  localparam int unsigned XW     = $clog2(WIDTH),
  localparam int unsigned YW     = $clog2(HEIGHT),
  localparam int unsigned CW     = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sof,
  input  logic             eol,
  input  logic             pixelValid,
  input  logic [15:0]      pixelData,
  output logic             resultValid,
  input  logic             resultAck,
  output logic             resultOverrun,
  output logic [CW-1:0]    pixelCount,
  output logic [CW+XW-1:0] sumX,
  output logic [CW+YW-1:0] sumY,
  output logic [XW-1:0]    minX,
  output logic [XW-1:0]    maxX,
  output logic [YW-1:0]    minY,
  output logic [YW-1:0]    maxY
);

  // x needs one extra bit so it can rest at WIDTH once the line overruns
  localparam int unsigned XCW = XW + 1;
  localparam int unsigned SXW = CW + XW;
  localparam int unsigned SYW = CW + YW;
  localparam logic [XCW-1:0] X_END = XCW'(WIDTH);
  localparam logic [YW-1:0]  Y_LAST = YW'(HEIGHT - 1);

  state_t state, state_next;
  logic   flush_cnt;

  logic [XCW-1:0] x, cur_x;
  logic [YW-1:0]  y, cur_y;
  logic           pix_match_c, accept_c, publish_c;

  logic           s1_match;
  logic [XW-1:0]  s1_x;
  logic [YW-1:0]  s1_y;

  logic [CW-1:0]  acc_cnt;
  logic [SXW-1:0] acc_sx;
  logic [SYW-1:0] acc_sy;
  logic [XW-1:0]  acc_minx, acc_maxx;
  logic [YW-1:0]  acc_miny, acc_maxy;

  colour_window_match #(
    .R_MIN(R_MIN),
    .G_MAX(G_MAX),
    .B_MIN(B_MIN)
  ) u_match (
    .pixel  (pixelData),
    .match_c(pix_match_c)
  );

  // Next state; a sof always restarts the frame, aborting any frame in progress
  always_comb begin
    state_next = state;
    accept_c   = sof || (state == ST_ACTIVE);
    publish_c  = (state == ST_PUBLISH) && !sof;
    cur_x      = sof ? '0 : x;
    cur_y      = sof ? '0 : y;
    case (state)
      ST_IDLE:    state_next = ST_IDLE;
      ST_ACTIVE:  if (eol && (y == Y_LAST)) state_next = ST_FLUSH;
      ST_FLUSH:   if (flush_cnt) state_next = ST_PUBLISH;
      ST_PUBLISH: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (sof) state_next = ST_ACTIVE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= (state == ST_FLUSH) && !flush_cnt;
    end
  end

  // Coordinate counters and pipeline stage 1 (match bit tagged with its coordinates)
  always_ff @(posedge clock) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      s1_match <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      if (sof) begin
        x <= pixelValid ? XCW'(1) : '0;
        y <= '0;
      end else if (state == ST_ACTIVE) begin
        if (eol) begin
          x <= '0;
          y <= y + 1'b1;
        end else if (pixelValid && (x != X_END)) begin
          x <= x + 1'b1;
        end
      end
      s1_match <= accept_c && pixelValid && (cur_x < X_END) && pix_match_c;
      s1_x     <= cur_x[XW-1:0];
      s1_y     <= cur_y;
    end
  end

  // Pipeline stage 2: accumulators; the first match seeds the bounding box
  always_ff @(posedge clock) begin
    if (reset || sof) begin
      acc_cnt  <= '0;
      acc_sx   <= '0;
      acc_sy   <= '0;
      acc_minx <= '0;
      acc_maxx <= '0;
      acc_miny <= '0;
      acc_maxy <= '0;
    end else if (s1_match) begin
      acc_cnt <= acc_cnt + 1'b1;
      acc_sx  <= acc_sx + SXW'(s1_x);
      acc_sy  <= acc_sy + SYW'(s1_y);
      if ((acc_cnt == '0) || (s1_x < acc_minx)) acc_minx <= s1_x;
      if ((acc_cnt == '0) || (s1_x > acc_maxx)) acc_maxx <= s1_x;
      if ((acc_cnt == '0) || (s1_y < acc_miny)) acc_miny <= s1_y;
      if ((acc_cnt == '0) || (s1_y > acc_maxy)) acc_maxy <= s1_y;
    end
  end

  // Result bank; a publish takes priority over a same-cycle ack
  always_ff @(posedge clock) begin
    if (reset) begin
      resultValid   <= 1'b0;
      resultOverrun <= 1'b0;
      pixelCount    <= '0;
      sumX          <= '0;
      sumY          <= '0;
      minX          <= '0;
      maxX          <= '0;
      minY          <= '0;
      maxY          <= '0;
    end else if (publish_c) begin
      resultValid   <= 1'b1;
      resultOverrun <= resultValid && !resultAck;
      pixelCount    <= acc_cnt;
      sumX          <= acc_sx;
      sumY          <= acc_sy;
      minX          <= acc_minx;
      maxX          <= acc_maxx;
      minY          <= acc_miny;
      maxY          <= acc_maxy;
    end else if (resultAck && resultValid) begin
      resultValid   <= 1'b0;
      resultOverrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blob_tracker.sv
// Bench for blob_tracker on a 4x2 frame: directed cases plus random frames checked against
// a frame-level reference model computed from the stored pixel array.
module tb_blob_tracker;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned XW = 2;
  localparam int unsigned YW = 1;
  localparam int unsigned CW = 4;

  logic clock;
  logic reset, sof, eol, pixelValid, resultAck;
  logic [15:0] pixelData;
  logic resultValid, resultOverrun;
  logic [CW-1:0]    pixelCount;
  logic [CW+XW-1:0] sumX;
  logic [CW+YW-1:0] sumY;
  logic [XW-1:0]    minX, maxX;
  logic [YW-1:0]    minY, maxY;

  blob_tracker #(
    .WIDTH (W),
    .HEIGHT(H),
    .R_MIN (24),
    .G_MAX (15),
    .B_MIN (24)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sof          (sof),
    .eol          (eol),
    .pixelValid   (pixelValid),
    .pixelData    (pixelData),
    .resultValid  (resultValid),
    .resultAck    (resultAck),
    .resultOverrun(resultOverrun),
    .pixelCount   (pixelCount),
    .sumX         (sumX),
    .sumY         (sumY),
    .minX         (minX),
    .maxX         (maxX),
    .minY         (minY),
    .maxY         (maxY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total, bad;
  logic [15:0] lpix [2][6];
  int llen [2];
  int e_cnt, e_sx, e_sy, e_minx, e_maxx, e_miny, e_maxy;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_magenta(input logic [15:0] p);
    return (p[15:11] >= 5'd24) && (p[10:5] <= 6'd15) && (p[4:0] >= 5'd24);
  endfunction

  // Reference: statistics of the stored frame; pixels beyond column W-1 never count
  task automatic model;
    e_cnt = 0; e_sx = 0; e_sy = 0;
    e_minx = 0; e_maxx = 0; e_miny = 0; e_maxy = 0;
    for (int yy = 0; yy < int'(H); yy++)
      for (int i = 0; i < llen[yy]; i++)
        if (i < int'(W) && is_magenta(lpix[yy][i])) begin
          if (e_cnt == 0) begin
            e_minx = i; e_maxx = i; e_miny = yy; e_maxy = yy;
          end else begin
            if (i < e_minx) e_minx = i;
            if (i > e_maxx) e_maxx = i;
            if (yy < e_miny) e_miny = yy;
            if (yy > e_maxy) e_maxy = yy;
          end
          e_cnt++;
          e_sx += i;
          e_sy += yy;
        end
  endtask

  task automatic fill(input logic [15:0] v, input int len);
    for (int yy = 0; yy < 2; yy++) begin
      llen[yy] = len;
      for (int i = 0; i < 6; i++) lpix[yy][i] = v;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rv"}, 32'(resultValid), 32'd0);
    chk({tag, "_ovr"}, 32'(resultOverrun), 32'd0);
    chk({tag, "_cnt"}, 32'(pixelCount), 32'd0);
    chk({tag, "_sumx"}, 32'(sumX), 32'd0);
    chk({tag, "_sumy"}, 32'(sumY), 32'd0);
    chk({tag, "_minx"}, 32'(minX), 32'd0);
    chk({tag, "_maxx"}, 32'(maxX), 32'd0);
    chk({tag, "_miny"}, 32'(minY), 32'd0);
    chk({tag, "_maxy"}, 32'(maxY), 32'd0);
  endtask

  task automatic check_result(input logic exp_ov);
    model;
    chk("count", 32'(pixelCount), 32'(e_cnt));
    chk("sumx", 32'(sumX), 32'(e_sx));
    chk("sumy", 32'(sumY), 32'(e_sy));
    chk("minx", 32'(minX), 32'(e_minx));
    chk("maxx", 32'(maxX), 32'(e_maxx));
    chk("miny", 32'(minY), 32'(e_miny));
    chk("maxy", 32'(maxY), 32'(e_maxy));
    chk("overrun", 32'(resultOverrun), 32'(exp_ov));
  endtask

  task automatic ack;
    resultAck = 1'b1;
    step;
    resultAck = 1'b0;
    chk("ack_rv", 32'(resultValid), 32'd0);
    chk("ack_ovr", 32'(resultOverrun), 32'd0);
  endtask

  // Sends the stored frame; resultValid must rise exactly 3 cycles after the final eol
  task automatic run_frame(input bit sof_pix, input bit eol_pix, input int gap_pct,
                           input bit ack_on_pub);
    logic prev;
    int first;
    prev = resultValid;
    sof = 1'b1;
    if (sof_pix) begin
      pixelValid = 1'b1;
      pixelData  = lpix[0][0];
    end
    step;
    sof = 1'b0;
    pixelValid = 1'b0;
    for (int yy = 0; yy < int'(H); yy++) begin
      first = (yy == 0 && sof_pix) ? 1 : 0;
      for (int i = first; i < llen[yy]; i++) begin
        if ($urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 2)) step;
        pixelValid = 1'b1;
        pixelData  = lpix[yy][i];
        if (eol_pix && i == llen[yy] - 1) eol = 1'b1;
        step;
        pixelValid = 1'b0;
        eol = 1'b0;
      end
      if (!eol_pix) begin
        eol = 1'b1;
        step;
        eol = 1'b0;
      end
    end
    for (int k = 1; k <= 3; k++) begin
      if (ack_on_pub && k == 3) resultAck = 1'b1;
      step;
      resultAck = 1'b0;
      if (k < 3) chk("rv_early", 32'(resultValid), 32'(prev));
      else       chk("rv_publish", 32'(resultValid), 32'd1);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; sof = 1'b0; eol = 1'b0; pixelValid = 1'b0;
    pixelData = 16'h0000; resultAck = 1'b0;
    repeat (3) step;
    check_zero_outputs("reset");
    reset = 1'b0;
    step;

    // full magenta frame
    fill(16'hF81F, 4);
    run_frame(1'b0, 1'b0, 0, 1'b0);
    check_result(1'b0);
    chk("full_count", 32'(pixelCount), 32'd8);
    ack;

    // single pixel at (2,1), eol shares the last pixel cycle
    fill(16'h0000, 4);
    lpix[1][2] = 16'hF81F;
    run_frame(1'b0, 1'b1, 0, 1'b0);
    check_result(1'b0);
    ack;

    // threshold edges, first pixel with sof, random gaps
    fill(16'h0000, 4);
    lpix[0][1] = 16'hC1F8;
    lpix[0][2] = 16'hB9F8;
    lpix[1][0] = 16'hC218;
    lpix[1][3] = 16'hC1F7;
    run_frame(1'b1, 1'b0, 30, 1'b0);
    check_result(1'b0);
    chk("thr_count", 32'(pixelCount), 32'd1);
    ack;

    // empty frame with overlong lines
    fill(16'h07E0, 6);
    run_frame(1'b0, 1'b1, 0, 1'b0);
    check_result(1'b0);
    ack;

    // overrun, then publish colliding with ack, then ack
    fill(16'hF81F, 4);
    run_frame(1'b0, 1'b0, 0, 1'b0);
    check_result(1'b0);
    fill(16'h0000, 4);
    lpix[0][3] = 16'hF81F;
    run_frame(1'b0, 1'b0, 0, 1'b0);
    check_result(1'b1);
    fill(16'h0000, 5);
    lpix[1][0] = 16'hF81F;
    lpix[1][1] = 16'hFFFF;
    lpix[1][4] = 16'hF81F;
    run_frame(1'b0, 1'b0, 0, 1'b1);
    check_result(1'b0);
    ack;

    // aborted frame with 3 matches, then a clean frame with 1 match
    sof = 1'b1;
    step;
    sof = 1'b0;
    repeat (3) begin
      pixelValid = 1'b1;
      pixelData  = 16'hF81F;
      step;
    end
    pixelValid = 1'b0;
    fill(16'h0000, 4);
    lpix[0][0] = 16'hF81F;
    run_frame(1'b0, 1'b0, 0, 1'b0);
    check_result(1'b0);
    chk("abort_count", 32'(pixelCount), 32'd1);
    ack;

    // reset mid-frame with a pending result; later pixels and eols are ignored in idle
    fill(16'hF81F, 4);
    run_frame(1'b0, 1'b0, 0, 1'b0);
    sof = 1'b1;
    step;
    sof = 1'b0;
    pixelValid = 1'b1;
    pixelData  = 16'hF81F;
    step; step;
    pixelValid = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    check_zero_outputs("midreset");
    for (int i = 0; i < 6; i++) begin
      pixelValid = 1'b1;
      eol = (i % 3 == 2) ? 1'b1 : 1'b0;
      step;
    end
    pixelValid = 1'b0;
    eol = 1'b0;
    repeat (6) step;
    chk("idle_no_publish", 32'(resultValid), 32'd0);

    // random frames
    for (int f = 0; f < 16; f++) begin
      for (int yy = 0; yy < 2; yy++) begin
        llen[yy] = int'($urandom_range(4, 6));
        for (int i = 0; i < 6; i++)
          lpix[yy][i] = {5'($urandom_range(20, 31)), 6'($urandom_range(0, 20)),
                         5'($urandom_range(20, 31))};
      end
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 40)), 1'b0);
      check_result(1'b0);
      repeat ($urandom_range(0, 3)) step;
      ack;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
